// File: rtl/traffic_generator.sv
// Synthetic packet source for a router Local input port: fixed-gap injection to
// pseudo-random legal destinations, driven over the Req/Gnt/Full handshake.
module traffic_generator #(
    parameter logic [5:0]  routerID       = 6'b000_000,
    parameter int          dataWidth      = 32,
    parameter int          dim            = 4,
    parameter int          injectInterval = 8,
    parameter int          maxPackets     = 100,
    parameter logic [15:0] lfsrSeed       = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 DnStrFull,
    input  logic                 GntDnStr,
    output logic                 ReqDnStr,
    output logic [dataWidth-1:0] PacketOut,
    output logic [9:0]           PacketsSent,
    output logic                 Done
);

    typedef enum logic [1:0] {WAIT_GAP, PICK_DEST, REQ, DONE} state_t;

    localparam logic [3:0] dimLimit = 4'(dim);

    state_t      state;
    logic [15:0] lfsr;
    logic [9:0]  packetID;
    logic [31:0] gapCnt;

    logic                 lfsrFb;
    logic [2:0]           candX;
    logic [2:0]           candY;
    logic                 destOk;
    logic                 maxReached;
    logic [dataWidth-1:0] candPacket;

    // Fibonacci LFSR, taps 16/14/13/11, shifting towards the MSB
    assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign candX  = lfsr[5:3];
    assign candY  = lfsr[2:0];
    assign destOk = ({1'b0, candX} < dimLimit) && ({1'b0, candY} < dimLimit)
                    && ({candX, candY} != routerID);

    assign maxReached = (maxPackets != 0) && ({22'd0, PacketsSent} == 32'(maxPackets));

    always_comb begin
        candPacket                   = '0;
        candPacket[dataWidth-1 -: 6] = {candX, candY};
        candPacket[15:6]             = packetID;
        candPacket[5:0]              = routerID;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_GAP;
            lfsr        <= lfsrSeed;
            packetID    <= '0;
            gapCnt      <= '0;
            ReqDnStr    <= 1'b0;
            PacketOut   <= '0;
            PacketsSent <= '0;
            Done        <= 1'b0;
        end else begin
            case (state)
                WAIT_GAP: begin
                    if (maxReached) begin
                        state    <= DONE;
                        Done     <= 1'b1;
                        ReqDnStr <= 1'b0;
                    end else if (enable) begin
                        if (gapCnt == 32'(injectInterval - 1)) begin
                            gapCnt <= '0;
                            state  <= PICK_DEST;
                        end else begin
                            gapCnt <= gapCnt + 32'd1;
                        end
                    end
                end
                PICK_DEST: begin
                    // Rejected candidates simply retry with the next LFSR value
                    lfsr <= {lfsr[14:0], lfsrFb};
                    if (destOk) begin
                        PacketOut <= candPacket;
                        ReqDnStr  <= ~DnStrFull;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    // A grant wins over a simultaneous Full
                    if (ReqDnStr && GntDnStr) begin
                        ReqDnStr <= 1'b0;
                        packetID <= packetID + 10'd1;
                        if (PacketsSent != 10'h3FF) begin
                            PacketsSent <= PacketsSent + 10'd1;
                        end
                        state <= WAIT_GAP;
                    end else begin
                        ReqDnStr <= ~DnStrFull;
                    end
                end
                DONE: begin
                    ReqDnStr <= 1'b0;
                    Done     <= 1'b1;
                end
                default: state <= WAIT_GAP;
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_generator.sv
// Scoreboard bench for traffic_generator: a reference LFSR picks the expected packets,
// which are queued on request and matched against PacketOut when the DUT raises ReqDnStr.
module tb_traffic_generator;

    localparam logic [5:0]  RID      = 6'b001_001;
    localparam int          INTERVAL = 4;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        DnStrFull = 1'b0;
    logic        GntDnStr = 1'b0;
    logic        ReqDnStr;
    logic [31:0] PacketOut;
    logic [9:0]  PacketsSent;
    logic        Done;

    logic        resetT = 1'b1;
    logic        enableT = 1'b0;
    logic        fullT = 1'b0;
    logic        gntT = 1'b0;
    logic        reqT;
    logic [31:0] pktT;
    logic [9:0]  sentT;
    logic        doneT;

    int checks = 0;
    int failures = 0;

    logic [15:0] mLfsr = SEED;
    logic [9:0]  mId = '0;
    int          mSent = 0;
    logic [31:0] lastExp = '0;
    logic [31:0] expQ[$];
    int          latQ[$];

    always #5 clk = ~clk;

    traffic_generator #(
        .routerID(RID), .dataWidth(32), .dim(3), .injectInterval(INTERVAL),
        .maxPackets(0), .lfsrSeed(SEED)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .DnStrFull(DnStrFull),
        .GntDnStr(GntDnStr), .ReqDnStr(ReqDnStr), .PacketOut(PacketOut),
        .PacketsSent(PacketsSent), .Done(Done)
    );

    traffic_generator #(
        .routerID(6'b000_000), .dataWidth(32), .dim(4), .injectInterval(3),
        .maxPackets(5), .lfsrSeed(SEED)
    ) dutTerm (
        .clk(clk), .reset(resetT), .enable(enableT), .DnStrFull(fullT),
        .GntDnStr(gntT), .ReqDnStr(reqT), .PacketOut(pktT),
        .PacketsSent(sentT), .Done(doneT)
    );

    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Next accepted packet from the reference generator, with its rejected-pick count
    task automatic modelNext(output logic [31:0] pkt, output int rej);
        logic [5:0] cand;
        rej = 0;
        while (1) begin
            cand  = mLfsr[5:0];
            mLfsr = lfsrStep(mLfsr);
            if (cand[5:3] < 3 && cand[2:0] < 3 && cand != RID) break;
            rej++;
        end
        pkt = {cand, 10'd0, mId, RID};
        mId = mId + 10'd1;
    endtask

    task automatic modelReset();
        mLfsr = SEED;
        mId   = '0;
        mSent = 0;
        expQ.delete();
        latQ.delete();
    endtask

    // Called right after enable rises, reset releases or a grant lands; leaves Req high
    task automatic expectPacket();
        logic [31:0] pkt;
        int rej;
        int cnt;
        int expLat;
        modelNext(pkt, rej);
        expQ.push_back(pkt);
        latQ.push_back(INTERVAL + 1 + rej);
        cnt = 0;
        while (cnt < 600) begin
            @(negedge clk);
            cnt++;
            if (ReqDnStr === 1'b1) break;
        end
        lastExp = expQ.pop_front();
        expLat  = latQ.pop_front();
        checks++;
        if (ReqDnStr !== 1'b1) begin
            failures++;
            $display("FAIL req_timeout: ReqDnStr=%b after %0d cycles, required 1", ReqDnStr, cnt);
            return;
        end
        checks++;
        if (PacketOut !== lastExp) begin
            failures++;
            $display("FAIL packet: PacketOut=%h, required %h", PacketOut, lastExp);
        end
        checks++;
        if (cnt !== expLat) begin
            failures++;
            $display("FAIL req_latency: %0d cycles, required %0d", cnt, expLat);
        end
    endtask

    task automatic grantNow();
        GntDnStr = 1'b1;
        @(negedge clk);
        GntDnStr = 1'b0;
        mSent = (mSent < 1023) ? mSent + 1 : 1023;
        checks++;
        if (ReqDnStr !== 1'b0) begin
            failures++;
            $display("FAIL req_after_grant: ReqDnStr=%b, required 0", ReqDnStr);
        end
        checks++;
        if (PacketsSent !== 10'(mSent)) begin
            failures++;
            $display("FAIL packets_sent: PacketsSent=%0d, required %0d", PacketsSent, mSent);
        end
        $display("txn grant id=%0d dest=%o sent=%0d t=%0t", lastExp[15:6], lastExp[31:26],
                 PacketsSent, $time);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        resetT = 1'b0;
        #1;
        checks++;
        if (ReqDnStr !== 1'b0 || PacketOut !== 32'd0 || PacketsSent !== 10'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: req=%b pkt=%h sent=%0d done=%b, required all 0",
                     ReqDnStr, PacketOut, PacketsSent, Done);
        end
        checks++;
        if (reqT !== 1'b0 || pktT !== 32'd0 || sentT !== 10'd0 || doneT !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_term: req=%b pkt=%h sent=%0d done=%b, required all 0",
                     reqT, pktT, sentT, doneT);
        end
        repeat (2) @(negedge clk);
        reset  = 1'b1;
        resetT = 1'b1;
    endtask

    task automatic test_basic();
        // Gap counter must stay frozen while enable is low
        repeat (6) begin
            @(negedge clk);
            checks++;
            if (ReqDnStr !== 1'b0) begin
                failures++;
                $display("FAIL req_while_disabled: ReqDnStr=%b, required 0", ReqDnStr);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expectPacket();
            @(negedge clk);
            checks++;
            if (ReqDnStr !== 1'b1 || PacketOut !== lastExp) begin
                failures++;
                $display("FAIL req_hold: req=%b pkt=%h, required 1 and %h", ReqDnStr, PacketOut, lastExp);
            end
            grantNow();
        end
    endtask

    task automatic test_backpressure();
        expectPacket();
        DnStrFull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            GntDnStr = (i == 4 || i == 5);
            @(negedge clk);
            checks++;
            if (ReqDnStr !== 1'b0 || PacketOut !== lastExp) begin
                failures++;
                $display("FAIL full_hold: req=%b pkt=%h, required 0 and %h", ReqDnStr, PacketOut, lastExp);
            end
        end
        GntDnStr = 1'b0;
        checks++;
        if (PacketsSent !== 10'(mSent)) begin
            failures++;
            $display("FAIL gnt_without_req: PacketsSent=%0d, required %0d", PacketsSent, mSent);
        end
        DnStrFull = 1'b0;
        @(negedge clk);
        checks++;
        if (ReqDnStr !== 1'b1 || PacketOut !== lastExp) begin
            failures++;
            $display("FAIL req_after_full: req=%b pkt=%h, required 1 and %h", ReqDnStr, PacketOut, lastExp);
        end
        grantNow();
        // Full and grant together: the grant must win
        expectPacket();
        DnStrFull = 1'b1;
        grantNow();
        DnStrFull = 1'b0;
    endtask

    task automatic test_legality_wrap();
        bit seen[64];
        int missing;
        logic [5:0] d;
        for (int n = 0; n < 1030; n++) begin
            expectPacket();
            d = PacketOut[31:26];
            checks++;
            if (d[5:3] >= 3 || d[2:0] >= 3 || d == RID) begin
                failures++;
                $display("FAIL dest_legal: destID=%o, required x<3, y<3, not %o", d, RID);
            end
            seen[d] = 1'b1;
            grantNow();
        end
        missing = 0;
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++)
                if ((x * 8 + y) != int'(RID) && !seen[x * 8 + y]) missing++;
        checks++;
        if (missing != 0) begin
            failures++;
            $display("FAIL dest_coverage: %0d legal nodes never chosen, required 0", missing);
        end
        checks++;
        if (PacketsSent !== 10'd1023) begin
            failures++;
            $display("FAIL sent_saturate: PacketsSent=%0d, required 1023", PacketsSent);
        end
    endtask

    task automatic test_async_reset();
        expectPacket();
        #2 reset = 1'b0;
        #1;
        checks++;
        if (ReqDnStr !== 1'b0 || PacketOut !== 32'd0 || Done !== 1'b0 || PacketsSent !== 10'd0) begin
            failures++;
            $display("FAIL async_reset: req=%b pkt=%h done=%b sent=%0d, required all 0",
                     ReqDnStr, PacketOut, Done, PacketsSent);
        end
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        expectPacket();
        grantNow();
    endtask

    task automatic test_termination();
        int grants = 0;
        int reqHigh = 0;
        enableT = 1'b1;
        for (int c = 0; c < 3000 && doneT !== 1'b1; c++) begin
            @(negedge clk);
            gntT = 1'b0;
            if (reqT === 1'b1) begin
                checks++;
                if (pktT[15:6] !== 10'(grants) || pktT[5:0] !== 6'd0) begin
                    failures++;
                    $display("FAIL term_packet: id=%0d sender=%o, required %0d and 0",
                             pktT[15:6], pktT[5:0], grants);
                end
                $display("txn term_grant id=%0d dest=%o t=%0t", pktT[15:6], pktT[31:26], $time);
                gntT = 1'b1;
                grants++;
            end
        end
        gntT = 1'b0;
        checks++;
        if (grants != 5 || doneT !== 1'b1 || sentT !== 10'd5) begin
            failures++;
            $display("FAIL termination: grants=%0d done=%b sent=%0d, required 5, 1, 5", grants, doneT, sentT);
        end
        repeat (100) begin
            @(negedge clk);
            if (reqT !== 1'b0 || doneT !== 1'b1) reqHigh++;
        end
        checks++;
        if (reqHigh != 0) begin
            failures++;
            $display("FAIL done_sticky: %0d cycles with req high or done low, required 0", reqHigh);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_legality_wrap();
        test_async_reset();
        test_termination();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
